trap_ctrl: RTL

Machine-mode trap sequencer that sits between the pipeline's exception/interrupt sources and the CSR register file. It arbitrates one synchronous exception, level-sensitive interrupt lines and `mret`. It drains the pipeline, then writes mepc/mcause/mtval/mstatus one CSR per cycle over a single write port. It finishes by issuing a one-cycle PC redirect to the trap vector, or to mepc for `mret`.

---
 rtl/trap_pkg.sv | 57 +++++
 rtl/irq_prio_enc.sv | 24 ++
 rtl/trap_ctrl.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/trap_pkg.sv
// Shared types, CSR addresses and mstatus field helpers for the machine-mode trap sequencer.
package trap_pkg;

    localparam int CAUSE_W = 5;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAIN,
        ST_SAVE_EPC,
        ST_SAVE_CAUSE,
        ST_SAVE_TVAL,
        ST_SAVE_STATUS,
        ST_REDIRECT
    } trap_state_e;

    typedef enum logic [1:0] {
        KIND_EXC  = 2'd0,
        KIND_IRQ  = 2'd1,
        KIND_MRET = 2'd2
    } trap_kind_e;

    typedef struct packed {
        trap_kind_e           kind;
        logic [31:0]          pc;
        logic [CAUSE_W-1:0]   cause;
        logic [31:0]          tval;
    } trap_req_t;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt lines.
module irq_prio_enc
    import trap_pkg::*;
#(
    parameter int NIRQ = 16
) (
    input  logic [NIRQ-1:0]    req,
    output logic               valid,
    output logic [CAUSE_W-1:0] idx
);

    // Scanning downward lets the last hit, i.e. the lowest index, win.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = CAUSE_W'(i);
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exception/interrupt/mret, drains the pipeline,
// writes mepc/mcause/mtval/mstatus one CSR per cycle, then redirects fetch.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int NIRQ = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                exc_req,
    input  logic [CAUSE_W-1:0]  exc_cause,
    input  logic [31:0]         exc_pc,
    input  logic [31:0]         exc_tval,
    input  logic [NIRQ-1:0]     irq_pending,
    input  logic [NIRQ-1:0]     irq_enable,
    input  logic [31:0]         int_pc,
    input  logic                mret_req,
    input  logic                pipe_idle,
    input  logic [31:0]         mstatus_in,
    input  logic [31:0]         mtvec_in,
    input  logic [31:0]         mepc_in,
    output logic                flush,
    output logic                trap_ack,
    output logic                csr_we,
    output logic [11:0]         csr_waddr,
    output logic [31:0]         csr_wdata,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,
    output logic                busy
);

    trap_state_e        state_q, state_d;
    trap_req_t          cap_q, req_d;
    logic               ack_q;
    logic               accept;
    logic               irq_valid;
    logic [CAUSE_W-1:0] irq_idx;
    logic               irq_eligible;
    logic [31:0]        vec_base;

    irq_prio_enc #(.NIRQ(NIRQ)) u_prio (
        .req   (irq_pending & irq_enable),
        .valid (irq_valid),
        .idx   (irq_idx)
    );

    assign irq_eligible = mstatus_in[MSTATUS_MIE] & irq_valid;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        req_d = '0;
        req_d.kind = KIND_MRET;
        if (exc_req) begin
            req_d.kind  = KIND_EXC;
            req_d.pc    = exc_pc;
            req_d.cause = exc_cause;
            req_d.tval  = exc_tval;
        end else if (irq_eligible) begin
            req_d.kind  = KIND_IRQ;
            req_d.pc    = int_pc;
            req_d.cause = irq_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (exc_req || irq_eligible || mret_req) begin
                    accept  = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (pipe_idle) begin
                    state_d = (cap_q.kind == KIND_MRET) ? ST_SAVE_STATUS : ST_SAVE_EPC;
                end
            end
            ST_SAVE_EPC:    state_d = ST_SAVE_CAUSE;
            ST_SAVE_CAUSE:  state_d = ST_SAVE_TVAL;
            ST_SAVE_TVAL:   state_d = ST_SAVE_STATUS;
            ST_SAVE_STATUS: state_d = ST_REDIRECT;
            ST_REDIRECT:    state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cap_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= accept;
            if (accept) begin
                cap_q <= req_d;
            end
        end
    end

    assign vec_base = {mtvec_in[31:2], 2'b00};

    // trap_ack is registered, so it pulses in the first DRAIN cycle after acceptance.
    always_comb begin
        flush          = (state_q != ST_IDLE);
        busy           = (state_q != ST_IDLE);
        trap_ack       = ack_q;
        csr_we         = 1'b0;
        csr_waddr      = '0;
        csr_wdata      = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        unique case (state_q)
            ST_SAVE_EPC: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MEPC;
                csr_wdata = {cap_q.pc[31:2], 2'b00};
            end
            ST_SAVE_CAUSE: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MCAUSE;
                csr_wdata = {cap_q.kind == KIND_IRQ, 26'b0, cap_q.cause};
            end
            ST_SAVE_TVAL: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MTVAL;
                csr_wdata = cap_q.tval;
            end
            ST_SAVE_STATUS: begin
                csr_we    = 1'b1;
                csr_waddr = CSR_MSTATUS;
                csr_wdata = (cap_q.kind == KIND_MRET) ? mstatus_on_mret(mstatus_in)
                                                      : mstatus_on_trap(mstatus_in);
            end
            ST_REDIRECT: begin
                redirect_valid = 1'b1;
                if (cap_q.kind == KIND_MRET) begin
                    redirect_pc = mepc_in;
                end else if (cap_q.kind == KIND_IRQ && mtvec_in[1:0] == 2'b01) begin
                    redirect_pc = vec_base + {25'b0, cap_q.cause, 2'b00};
                end else begin
                    redirect_pc = vec_base;
                end
            end
            default: ;
        endcase
    end

endmodule
